// File: rtl/div_serial_check_pkg.sv
// Shared definitions for the serial divisibility checker:
// FSM state encoding, default divisors and the remainder-width helper.
package div_serial_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV_A = 2;
    localparam int DEF_DIV_B = 3;
    localparam int DEF_DIV_C = 6;

    // Bits needed to hold a remainder of the largest divisor, never below 1.
    function automatic int rem_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/div_serial_check_mod_step.sv
// One MSB-first remainder step: r' = (2r + b) mod D using a single
// conditional subtract, since 2r + b is always below 2D.
module mod_step #(
    parameter int D  = 2,
    parameter int RW = 1
) (
    input  logic [RW-1:0] r,
    input  logic          b,
    output logic [RW-1:0] r_next
);

    // One extra bit so 2r + b never overflows before the compare.
    localparam logic [RW:0] D_VAL = (RW+1)'(D);

    logic [RW:0] t;

    // Form 2r + b and fold it back into [0, D).
    always_comb begin
        t      = {r, b};
        r_next = (t >= D_VAL) ? RW'(t - D_VAL) : t[RW-1:0];
    end

endmodule

// File: rtl/div_serial_check.sv
// Serial divisibility checker: takes a word over valid/ready, shifts it in
// MSB-first one bit per cycle while tracking the remainder modulo three
// divisors, then presents flags and remainders over valid/ready.
module div_serial_check
    import div_serial_check_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_A = DEF_DIV_A,
    parameter int DIV_B = DEF_DIV_B,
    parameter int DIV_C = DEF_DIV_C
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [WIDTH-1:0]                        in,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [2:0]                              divs,
    output logic [rem_width(DIV_A,DIV_B,DIV_C)-1:0] rem_a,
    output logic [rem_width(DIV_A,DIV_B,DIV_C)-1:0] rem_b,
    output logic [rem_width(DIV_A,DIV_B,DIV_C)-1:0] rem_c
);

    localparam int REM_W = rem_width(DIV_A, DIV_B, DIV_C);
    localparam int CNT_W = $clog2(WIDTH + 1);
    // Index 0 is divisor C so that divs[gi] lines up with {byA,byB,byC}.
    localparam int DIV_LIST [3] = '{DIV_C, DIV_B, DIV_A};

    if (DIV_A < 1 || DIV_B < 1 || DIV_C < 1 || WIDTH < 1) begin : g_param_check
        $error("div_serial_check: WIDTH and all divisors must be >= 1");
    end

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               accept;
    logic               last_step;
    logic [REM_W-1:0]   rem_all [3];
    logic [2:0]         flag_all;

    assign accept    = (state_reg == IDLE) && in_valid;
    assign last_step = (state_reg == SHIFT) && (count_reg == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: accept in IDLE, WIDTH shift cycles, hold until consumed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Shift register and bit counter; a new word reloads both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            count_reg <= '0;
        end else if (accept) begin
            shift_reg <= in;
            count_reg <= '0;
        end else if (state_reg == SHIFT) begin
            shift_reg <= shift_reg << 1;
            count_reg <= count_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_div
        logic [REM_W-1:0] work_reg;
        logic [REM_W-1:0] step_next;
        logic [REM_W-1:0] res_reg;
        logic             flag_reg;

        mod_step #(
            .D  (DIV_LIST[gi]),
            .RW (REM_W)
        ) u_step (
            .r      (work_reg),
            .b      (shift_reg[WIDTH-1]),
            .r_next (step_next)
        );

        // Running remainder; results latch only on the final shift.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                work_reg <= '0;
                res_reg  <= '0;
                flag_reg <= 1'b0;
            end else if (accept) begin
                work_reg <= '0;
            end else if (state_reg == SHIFT) begin
                work_reg <= step_next;
                if (last_step) begin
                    res_reg  <= step_next;
                    flag_reg <= (step_next == '0);
                end
            end
        end

        assign rem_all[gi]  = res_reg;
        assign flag_all[gi] = flag_reg;
    end

    assign divs  = flag_all;
    assign rem_a = rem_all[2];
    assign rem_b = rem_all[1];
    assign rem_c = rem_all[0];

endmodule

// File: tb/tb_div_serial_check.sv
// Directed bench for div_serial_check with default parameters (WIDTH=8, 2/3/6).
module tb_div_serial_check;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] divs;
    logic [2:0] rem_a, rem_b, rem_c;

    int n_tests = 0;
    int n_fail  = 0;

    div_serial_check dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .divs      (divs),
        .rem_a     (rem_a),
        .rem_b     (rem_b),
        .rem_c     (rem_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word for one edge (edge 0 of the transaction).
    task automatic start_word(input logic [7:0] v);
        @(negedge clk);
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges (handshake edge included) until out_valid; bounded.
    task automatic wait_result(input string tag);
        int edges;
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_latency"}, edges, 9);
    endtask

    task automatic check_result(input string tag, input logic [2:0] ed,
                                input int ra, input int rb, input int rc);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_divs"},  divs, ed);
        chk({tag, "_rem_a"}, rem_a, ra);
        chk({tag, "_rem_b"}, rem_b, rb);
        chk({tag, "_rem_c"}, rem_c, rc);
        $display("[TB] %s in=%0d divs=%b rem_a=%0d rem_b=%0d rem_c=%0d",
                 tag, in_data, divs, rem_a, rem_b, rem_c);
    endtask

    // Full transaction with out_ready already high: result, then back to IDLE.
    task automatic run_word(input string tag, input logic [7:0] v, input logic [2:0] ed,
                            input int ra, input int rb, input int rc);
        start_word(v);
        wait_result(tag);
        check_result(tag, ed, ra, rb, rc);
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, in_ready, 1);
        chk({tag, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        // 1. Reset state, then idle after release.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_divs", divs, 0);
        chk("rst_rems", {rem_a, rem_b, rem_c}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_divs", divs, 0);

        // 2-4. Directed words.
        run_word("w12",  8'd12,  3'b111, 0, 0, 0);
        run_word("w9",   8'd9,   3'b010, 1, 0, 3);
        run_word("w0",   8'd0,   3'b111, 0, 0, 0);
        run_word("w255", 8'd255, 3'b010, 1, 0, 3);
        run_word("w11",  8'd11,  3'b000, 1, 2, 5);

        // 5. Backpressure in DONE; in_valid pulses ignored in SHIFT and DONE.
        out_ready = 1'b0;
        start_word(8'd4);
        @(negedge clk);
        in_data  = 8'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_shift_in_ready", in_ready, 0);
        in_data = 8'd4;
        begin
            int edges;
            edges = 2;
            while (!out_valid && edges < 40) begin
                @(posedge clk); #1;
                edges++;
            end
            chk("bp_latency", edges, 9);
        end
        check_result("bp", 3'b100, 0, 1, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_data  = 8'd5;
            in_valid = (i == 2);
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_divs", divs, 3'b100);
            chk("bp_hold_rems", {rem_a, rem_b, rem_c}, {3'd0, 3'd1, 3'd4});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_no_spurious_valid", out_valid, 0);

        // 6. Reset in the middle of SHIFT aborts the word.
        start_word(8'd7);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_pre_valid", out_valid, 0);
        chk("abort_pre_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_divs", divs, 0);
        chk("abort_rems", {rem_a, rem_b, rem_c}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_word("w6", 8'd6, 3'b111, 0, 0, 0);

        // Sweep 0..15 against the combinational 2/3/6 golden model.
        for (int n = 0; n < 16; n++) begin
            logic [2:0] ed;
            ed = {(n % 2) == 0, (n % 3) == 0, (n % 6) == 0};
            run_word($sformatf("sweep%0d", n), 8'(n), ed, n % 2, n % 3, n % 6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
